// File: rtl/qsn_shift_scheduler_len15.sv
// Shift-table scheduler for a length-15 QSN: walks a layer/column table and emits decoded shifter controls.
// Optional macro QSN_SCHED_SKIP_NULL_EN: null circulants are skipped instead of issued.
module qsn_shift_scheduler_len15 #(
   parameter  int COL_NUM   = 10,
   parameter  int LAYER_NUM = 3,
   localparam int DEPTH     = COL_NUM * LAYER_NUM,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW        = (COL_NUM > 1) ? $clog2(COL_NUM) : 1,
   localparam int LW        = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1
) (
   input  logic          sys_clk,
   input  logic          rstn,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [3:0]    cfg_data,
   input  logic          start,
   input  logic          shift_ready,
   output logic          shift_valid,
   output logic [3:0]    shift_factor,
   output logic          shift_null,
   output logic [CW-1:0] col_idx,
   output logic [LW-1:0] layer_idx,
   output logic [3:0]    left_sel,
   output logic [3:0]    right_sel,
   output logic [13:0]   merge_sel,
   output logic          busy,
   output logic          done
);

`ifdef QSN_SCHED_SKIP_NULL_EN
   localparam logic SKIP_NULL = 1'b1;
`else
   localparam logic SKIP_NULL = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t        state;
   logic [3:0]    table_mem [DEPTH];
   logic [CW-1:0] nxt_col;
   logic [LW-1:0] nxt_layer;
   logic [AW-1:0] rd_addr;
   logic [3:0]    rd_data;
   logic          nxt_null;
   logic          nxt_valid;
   logic [21:0]   nxt_dec;
   logic          adv;
   logic          last;

   // Selects for shift s: left=s, right=15-s, merge has (15-s) low ones; 0 and null decode to all zero.
   function automatic logic [21:0] qsn_decode(input logic [3:0] s);
      logic [3:0]  r;
      logic [14:0] m;
      r = 4'd0;
      m = 15'd0;
      if (s == 4'd0 || s == 4'hF) begin
         qsn_decode = 22'd0;
      end else begin
         r = 4'd15 - s;
         m = (15'd1 << r) - 15'd1;
         qsn_decode = {s, r, m[13:0]};
      end
   endfunction

   // Next entry index and its table contents; outside RUN this is entry 0 for the pass start.
   always_comb begin
      nxt_col   = '0;
      nxt_layer = '0;
      if (state == RUN) begin
         if (col_idx == CW'(COL_NUM - 1)) begin
            nxt_col   = '0;
            nxt_layer = layer_idx + LW'(1);
         end else begin
            nxt_col   = col_idx + CW'(1);
            nxt_layer = layer_idx;
         end
      end else begin
         nxt_col   = '0;
         nxt_layer = '0;
      end
      rd_addr = AW'(nxt_layer) * AW'(COL_NUM) + AW'(nxt_col);
      if ({1'b0, rd_addr} < (AW + 1)'(DEPTH)) begin
         rd_data = table_mem[rd_addr];
      end else begin
         rd_data = 4'h0;
      end
      nxt_null  = (rd_data == 4'hF);
      nxt_valid = !(SKIP_NULL && nxt_null);
      nxt_dec   = qsn_decode(rd_data);
      // A skipped (invalid) cycle in RUN advances on its own.
      adv  = (state == RUN) && (shift_valid ? shift_ready : 1'b1);
      last = (col_idx == CW'(COL_NUM - 1)) && (layer_idx == LW'(LAYER_NUM - 1));
   end

   // Shift table: writable only while idle.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_mem[i] <= 4'h0;
         end
      end else if (cfg_we && (state == IDLE) && ({1'b0, cfg_addr} < (AW + 1)'(DEPTH))) begin
         table_mem[cfg_addr] <= cfg_data;
      end
   end

   // Pass sequencing with fully registered outputs.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         shift_valid  <= 1'b0;
         shift_factor <= 4'h0;
         shift_null   <= 1'b0;
         col_idx      <= '0;
         layer_idx    <= '0;
         {left_sel, right_sel, merge_sel} <= 22'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state        <= RUN;
                  busy         <= 1'b1;
                  shift_valid  <= nxt_valid;
                  shift_factor <= rd_data;
                  shift_null   <= nxt_null;
                  col_idx      <= nxt_col;
                  layer_idx    <= nxt_layer;
                  {left_sel, right_sel, merge_sel} <= nxt_dec;
               end
            end
            RUN: begin
               if (adv) begin
                  if (last) begin
                     state        <= DONE;
                     done         <= 1'b1;
                     shift_valid  <= 1'b0;
                     shift_factor <= 4'h0;
                     shift_null   <= 1'b0;
                     col_idx      <= '0;
                     layer_idx    <= '0;
                     {left_sel, right_sel, merge_sel} <= 22'd0;
                  end else begin
                     shift_valid  <= nxt_valid;
                     shift_factor <= rd_data;
                     shift_null   <= nxt_null;
                     col_idx      <= nxt_col;
                     layer_idx    <= nxt_layer;
                     {left_sel, right_sel, merge_sel} <= nxt_dec;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               busy        <= 1'b0;
               done        <= 1'b0;
               shift_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
